// File: rtl/cpl_enqueue_initiator.sv
// Completion enqueue initiator: takes one completion record, reserves a slot from the
// queue manager, writes the record with the phase bit by DMA, then commits the slot.
module cpl_enqueue_initiator #(
  parameter int QUEUE_INDEX_WIDTH = 8,
  parameter int REQ_TAG_WIDTH     = 8,
  parameter int OP_TAG_WIDTH      = 8,
  parameter int QUEUE_PTR_WIDTH   = 16,
  parameter int ADDR_WIDTH        = 64,
  parameter int CPL_WIDTH         = 128
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_cpl_queue,
  input  logic [CPL_WIDTH-1:0]         s_axis_cpl_data,
  input  logic                         s_axis_cpl_valid,
  output logic                         s_axis_cpl_ready,

  output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_enqueue_req_queue,
  output logic [REQ_TAG_WIDTH-1:0]     m_axis_enqueue_req_tag,
  output logic                         m_axis_enqueue_req_valid,
  input  logic                         m_axis_enqueue_req_ready,

  input  logic [REQ_TAG_WIDTH-1:0]     s_axis_enqueue_resp_tag,
  input  logic [OP_TAG_WIDTH-1:0]      s_axis_enqueue_resp_op_tag,
  input  logic [ADDR_WIDTH-1:0]        s_axis_enqueue_resp_addr,
  input  logic                         s_axis_enqueue_resp_phase,
  input  logic                         s_axis_enqueue_resp_full,
  input  logic                         s_axis_enqueue_resp_error,
  input  logic                         s_axis_enqueue_resp_valid,
  output logic                         s_axis_enqueue_resp_ready,

  output logic [ADDR_WIDTH-1:0]        m_axis_dma_addr,
  output logic [CPL_WIDTH-1:0]         m_axis_dma_data,
  output logic                         m_axis_dma_valid,
  input  logic                         m_axis_dma_ready,
  input  logic                         dma_done,

  output logic [OP_TAG_WIDTH-1:0]      m_axis_enqueue_commit_op_tag,
  output logic                         m_axis_enqueue_commit_valid,
  input  logic                         m_axis_enqueue_commit_ready,

  output logic [31:0]                  drop_count,
  output logic [31:0]                  mismatch_count,
  output logic                         busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] REQ       = 3'd1;
  localparam logic [2:0] RESP      = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] COMMIT    = 3'd5;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [2:0]                   state;
  logic [REQ_TAG_WIDTH-1:0]     tag_cnt;
  logic [REQ_TAG_WIDTH-1:0]     out_tag_q;
  logic [QUEUE_INDEX_WIDTH-1:0] queue_q;
  logic [CPL_WIDTH-1:0]         data_q;
  logic [ADDR_WIDTH-1:0]        addr_q;
  logic [OP_TAG_WIDTH-1:0]      op_tag_q;

  logic cpl_hs, req_hs, resp_hs, resp_match, resp_ok, dma_hs, commit_hs;

  assign cpl_hs     = s_axis_cpl_valid && (state == IDLE);
  assign req_hs     = m_axis_enqueue_req_ready && (state == REQ);
  assign resp_hs    = s_axis_enqueue_resp_valid && (state == RESP);
  assign resp_match = (s_axis_enqueue_resp_tag == out_tag_q);
  assign resp_ok    = !s_axis_enqueue_resp_full && !s_axis_enqueue_resp_error;
  assign dma_hs     = m_axis_dma_ready && (state == WRITE);
  assign commit_hs  = m_axis_enqueue_commit_ready && (state == COMMIT);

  // Control: state, tag counter and status counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      tag_cnt        <= '0;
      drop_count     <= '0;
      mismatch_count <= '0;
    end else begin
      case (state)
        IDLE:      if (cpl_hs) state <= REQ;
        REQ: begin
          if (req_hs) begin
            tag_cnt <= tag_cnt + REQ_TAG_WIDTH'(1);
            state   <= RESP;
          end
        end
        RESP: begin
          if (resp_hs) begin
            if (!resp_match) begin
              mismatch_count <= sat_inc(mismatch_count);
            end else if (!resp_ok) begin
              drop_count <= sat_inc(drop_count);
              state      <= IDLE;
            end else begin
              state <= WRITE;
            end
          end
        end
        WRITE:     if (dma_hs) state <= WAIT_DONE;
        WAIT_DONE: if (dma_done) state <= COMMIT;
        COMMIT:    if (commit_hs) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Data: payload registers need no reset, they are only observed behind a valid.
  // The record MSB is overwritten with the slot phase so the DMA payload is data_q as-is.
  always_ff @(posedge clk) begin
    if (cpl_hs) begin
      queue_q <= s_axis_cpl_queue;
      data_q  <= s_axis_cpl_data;
    end
    if (req_hs) out_tag_q <= tag_cnt;
    if (resp_hs && resp_match && resp_ok) begin
      addr_q              <= s_axis_enqueue_resp_addr;
      op_tag_q            <= s_axis_enqueue_resp_op_tag;
      data_q[CPL_WIDTH-1] <= s_axis_enqueue_resp_phase;
    end
  end

  assign s_axis_cpl_ready             = (state == IDLE);
  assign m_axis_enqueue_req_valid     = (state == REQ);
  assign m_axis_enqueue_req_queue     = queue_q;
  assign m_axis_enqueue_req_tag       = tag_cnt;
  assign s_axis_enqueue_resp_ready    = (state == RESP);
  assign m_axis_dma_valid             = (state == WRITE);
  assign m_axis_dma_addr              = addr_q;
  assign m_axis_dma_data              = data_q;
  assign m_axis_enqueue_commit_valid  = (state == COMMIT);
  assign m_axis_enqueue_commit_op_tag = op_tag_q;
  assign busy                         = (state != IDLE);

endmodule

// File: tb/tb_cpl_enqueue_initiator.sv
// Bench for cpl_enqueue_initiator: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a transaction-level reference model.
module tb_cpl_enqueue_initiator;
  localparam int QW = 8, TW = 8, OW = 8, PW = 16, AW = 64, CW = 128;
  localparam int TAGS = 1 << TW;
  localparam int M_IDLE = 0, M_REQ = 1, M_RESP = 2, M_WRITE = 3, M_WAIT = 4, M_COMMIT = 5;

  logic clk = 0, rst_n = 0;
  logic [QW-1:0] s_axis_cpl_queue = '0;
  logic [CW-1:0] s_axis_cpl_data = '0;
  logic s_axis_cpl_valid = 0, s_axis_cpl_ready;
  logic [QW-1:0] m_axis_enqueue_req_queue;
  logic [TW-1:0] m_axis_enqueue_req_tag;
  logic m_axis_enqueue_req_valid, m_axis_enqueue_req_ready = 1;
  logic [TW-1:0] s_axis_enqueue_resp_tag = '0;
  logic [OW-1:0] s_axis_enqueue_resp_op_tag = '0;
  logic [AW-1:0] s_axis_enqueue_resp_addr = '0;
  logic s_axis_enqueue_resp_phase = 0, s_axis_enqueue_resp_full = 0, s_axis_enqueue_resp_error = 0;
  logic s_axis_enqueue_resp_valid = 0, s_axis_enqueue_resp_ready;
  logic [AW-1:0] m_axis_dma_addr;
  logic [CW-1:0] m_axis_dma_data;
  logic m_axis_dma_valid, m_axis_dma_ready = 1, dma_done = 0;
  logic [OW-1:0] m_axis_enqueue_commit_op_tag;
  logic m_axis_enqueue_commit_valid, m_axis_enqueue_commit_ready = 1;
  logic [31:0] drop_count, mismatch_count;
  logic busy;

  cpl_enqueue_initiator #(
    .QUEUE_INDEX_WIDTH(QW), .REQ_TAG_WIDTH(TW), .OP_TAG_WIDTH(OW),
    .QUEUE_PTR_WIDTH(PW), .ADDR_WIDTH(AW), .CPL_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_cpl_queue(s_axis_cpl_queue), .s_axis_cpl_data(s_axis_cpl_data),
    .s_axis_cpl_valid(s_axis_cpl_valid), .s_axis_cpl_ready(s_axis_cpl_ready),
    .m_axis_enqueue_req_queue(m_axis_enqueue_req_queue), .m_axis_enqueue_req_tag(m_axis_enqueue_req_tag),
    .m_axis_enqueue_req_valid(m_axis_enqueue_req_valid), .m_axis_enqueue_req_ready(m_axis_enqueue_req_ready),
    .s_axis_enqueue_resp_tag(s_axis_enqueue_resp_tag), .s_axis_enqueue_resp_op_tag(s_axis_enqueue_resp_op_tag),
    .s_axis_enqueue_resp_addr(s_axis_enqueue_resp_addr), .s_axis_enqueue_resp_phase(s_axis_enqueue_resp_phase),
    .s_axis_enqueue_resp_full(s_axis_enqueue_resp_full), .s_axis_enqueue_resp_error(s_axis_enqueue_resp_error),
    .s_axis_enqueue_resp_valid(s_axis_enqueue_resp_valid), .s_axis_enqueue_resp_ready(s_axis_enqueue_resp_ready),
    .m_axis_dma_addr(m_axis_dma_addr), .m_axis_dma_data(m_axis_dma_data),
    .m_axis_dma_valid(m_axis_dma_valid), .m_axis_dma_ready(m_axis_dma_ready), .dma_done(dma_done),
    .m_axis_enqueue_commit_op_tag(m_axis_enqueue_commit_op_tag),
    .m_axis_enqueue_commit_valid(m_axis_enqueue_commit_valid),
    .m_axis_enqueue_commit_ready(m_axis_enqueue_commit_ready),
    .drop_count(drop_count), .mismatch_count(mismatch_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, obs_commits = 0;
  logic chk_en = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: one completion in flight, tracked as transaction step plus its record
  int m_st = M_IDLE, m_tag = 0, m_out = 0;
  logic [QW-1:0] m_q;
  logic [CW-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic [OW-1:0] m_op;
  logic m_ph;
  longint m_drop = 0, m_mis = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_st <= M_IDLE; m_tag <= 0; m_drop <= 0; m_mis <= 0;
    end else begin
      case (m_st)
        M_IDLE: if (s_axis_cpl_valid) begin
          m_q <= s_axis_cpl_queue; m_data <= s_axis_cpl_data; m_st <= M_REQ;
        end
        M_REQ: if (m_axis_enqueue_req_ready) begin
          m_out <= m_tag; m_tag <= (m_tag + 1) % TAGS; m_st <= M_RESP;
        end
        M_RESP: if (s_axis_enqueue_resp_valid) begin
          if (int'(s_axis_enqueue_resp_tag) != m_out)
            m_mis <= (m_mis >= 64'hFFFF_FFFF) ? m_mis : m_mis + 1;
          else if (s_axis_enqueue_resp_full || s_axis_enqueue_resp_error) begin
            m_drop <= (m_drop >= 64'hFFFF_FFFF) ? m_drop : m_drop + 1;
            m_st <= M_IDLE;
          end else begin
            m_addr <= s_axis_enqueue_resp_addr; m_op <= s_axis_enqueue_resp_op_tag;
            m_ph <= s_axis_enqueue_resp_phase; m_st <= M_WRITE;
          end
        end
        M_WRITE:  if (m_axis_dma_ready) m_st <= M_WAIT;
        M_WAIT:   if (dma_done) m_st <= M_COMMIT;
        M_COMMIT: if (m_axis_enqueue_commit_ready) m_st <= M_IDLE;
        default:  m_st <= M_IDLE;
      endcase
    end
  end

  // Per-cycle compare plus payload-stability tracking under backpressure
  logic p_rst = 0, p_rv = 0, p_rr = 0, p_dv = 0, p_dr = 0, p_cv = 0, p_cr = 0;
  logic [127:0] p_req, p_dma_a, p_dma_d, p_cmt;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpl_ready", s_axis_cpl_ready, m_st == M_IDLE);
      chk("req_valid", m_axis_enqueue_req_valid, m_st == M_REQ);
      chk("resp_ready", s_axis_enqueue_resp_ready, m_st == M_RESP);
      chk("dma_valid", m_axis_dma_valid, m_st == M_WRITE);
      chk("commit_valid", m_axis_enqueue_commit_valid, m_st == M_COMMIT);
      chk("busy", busy, m_st != M_IDLE);
      chk("drop_count", drop_count, m_drop);
      chk("mismatch_count", mismatch_count, m_mis);
      if (m_st == M_REQ) begin
        chk("req_queue", m_axis_enqueue_req_queue, m_q);
        chk("req_tag", m_axis_enqueue_req_tag, m_tag);
      end
      if (m_st == M_WRITE) begin
        chk("dma_addr", m_axis_dma_addr, m_addr);
        chk("dma_data", m_axis_dma_data, {m_ph, m_data[CW-2:0]});
      end
      if (m_st == M_COMMIT) chk("commit_op_tag", m_axis_enqueue_commit_op_tag, m_op);
      if (p_rst && p_rv && !p_rr) chk("req_stable", {m_axis_enqueue_req_queue, m_axis_enqueue_req_tag}, p_req);
      if (p_rst && p_dv && !p_dr) begin
        chk("dma_addr_stable", m_axis_dma_addr, p_dma_a);
        chk("dma_data_stable", m_axis_dma_data, p_dma_d);
      end
      if (p_rst && p_cv && !p_cr) chk("commit_stable", m_axis_enqueue_commit_op_tag, p_cmt);
      if (m_axis_enqueue_commit_valid && m_axis_enqueue_commit_ready) obs_commits++;
      p_rst = rst_n;
      p_rv = m_axis_enqueue_req_valid; p_rr = m_axis_enqueue_req_ready;
      p_dv = m_axis_dma_valid; p_dr = m_axis_dma_ready;
      p_cv = m_axis_enqueue_commit_valid; p_cr = m_axis_enqueue_commit_ready;
      p_req = {m_axis_enqueue_req_queue, m_axis_enqueue_req_tag};
      p_dma_a = m_axis_dma_addr; p_dma_d = m_axis_dma_data; p_cmt = m_axis_enqueue_commit_op_tag;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return s_axis_cpl_ready;
      1: return m_axis_enqueue_req_valid;
      2: return s_axis_enqueue_resp_ready;
      3: return m_axis_dma_valid;
      default: return m_axis_enqueue_commit_valid;
    endcase
  endfunction

  task automatic wait_for(input int w, input string nm);
    for (int i = 0; i < 100 && !sel(w); i++) step();
    chk({"wait_", nm}, sel(w), 1'b1);
  endtask

  task automatic reset_dut();
    rst_n = 0; step(); step(); rst_n = 1;
  endtask

  task automatic send_cpl(input logic [QW-1:0] q, input logic [CW-1:0] d);
    s_axis_cpl_queue = q; s_axis_cpl_data = d; s_axis_cpl_valid = 1;
    wait_for(0, "cpl_ready");
    step();
    s_axis_cpl_valid = 0;
  endtask

  task automatic respond(input logic [TW-1:0] t, input logic [AW-1:0] a, input logic ph,
                         input logic [OW-1:0] op, input logic full, input logic err);
    wait_for(2, "resp_ready");
    s_axis_enqueue_resp_tag = t; s_axis_enqueue_resp_addr = a; s_axis_enqueue_resp_phase = ph;
    s_axis_enqueue_resp_op_tag = op; s_axis_enqueue_resp_full = full; s_axis_enqueue_resp_error = err;
    s_axis_enqueue_resp_valid = 1;
    step();
    s_axis_enqueue_resp_valid = 0;
  endtask

  function automatic logic [CW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [CW-1:0] d;
  logic [TW-1:0] t, pend_tag;
  logic hs_cpl, hs_req, hs_resp;
  int pend, c0;

  initial begin
    step();
    chk_en = 1;
    step(); rst_n = 1;
    chk("rst_cpl_ready", s_axis_cpl_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_valid", m_axis_enqueue_req_valid, 1'b0);
    chk("rst_drop", drop_count, 32'd0);

    // Nominal path
    d = rnd_data();
    send_cpl(8'd3, d);
    chk("nom_req_valid", m_axis_enqueue_req_valid, 1'b1);
    chk("nom_req_queue", m_axis_enqueue_req_queue, 8'd3);
    chk("nom_req_tag", m_axis_enqueue_req_tag, 8'd0);
    respond(8'd0, 64'h1000, 1'b1, 8'd5, 1'b0, 1'b0);
    chk("nom_dma_valid", m_axis_dma_valid, 1'b1);
    chk("nom_dma_addr", m_axis_dma_addr, 64'h1000);
    chk("nom_dma_msb", m_axis_dma_data[CW-1], 1'b1);
    chk("nom_dma_low", m_axis_dma_data[CW-2:0], d[CW-2:0]);
    step();
    chk("nom_wait_no_commit", m_axis_enqueue_commit_valid, 1'b0);
    dma_done = 1; step(); dma_done = 0;
    chk("nom_commit_valid", m_axis_enqueue_commit_valid, 1'b1);
    chk("nom_commit_op", m_axis_enqueue_commit_op_tag, 8'd5);
    step();
    chk("nom_busy_done", busy, 1'b0);

    // Full response drops the completion
    send_cpl(8'd9, rnd_data());
    respond(8'd1, 64'h2000, 1'b0, 8'd6, 1'b1, 1'b0);
    chk("full_drop", drop_count, 32'd1);
    chk("full_busy", busy, 1'b0);
    step();
    chk("full_no_dma", m_axis_dma_valid, 1'b0);
    chk("full_no_commit", m_axis_enqueue_commit_valid, 1'b0);

    // Tag mismatch, then matching response
    reset_dut();
    send_cpl(8'd4, rnd_data());
    respond(8'd7, 64'h5000, 1'b1, 8'd1, 1'b0, 1'b0);
    chk("mis_count", mismatch_count, 32'd1);
    chk("mis_still_resp", s_axis_enqueue_resp_ready, 1'b1);
    respond(8'd0, 64'h2000, 1'b0, 8'd9, 1'b0, 1'b0);
    chk("mis_dma_addr", m_axis_dma_addr, 64'h2000);
    chk("mis_dma_msb", m_axis_dma_data[CW-1], 1'b0);
    step(); dma_done = 1; step(); dma_done = 0;
    chk("mis_commit_op", m_axis_enqueue_commit_op_tag, 8'd9);
    step();

    // Tag wrap over 257 requests, alternating full and error responses
    reset_dut();
    for (int k = 0; k < 257; k++) begin
      send_cpl(QW'(k), rnd_data());
      t = m_axis_enqueue_req_tag;
      if (k == 0)   chk("wrap_tag_first", t, 8'd0);
      if (k == 255) chk("wrap_tag_255", t, 8'd255);
      if (k == 256) chk("wrap_tag_257", t, 8'd0);
      respond(t, 64'h0, 1'b0, 8'd0, k % 2 == 0, k % 2 == 1);
    end
    chk("wrap_drop", drop_count, 32'd257);

    // Backpressure on request, DMA and commit
    reset_dut();
    c0 = obs_commits;
    m_axis_enqueue_req_ready = 0;
    send_cpl(8'd5, rnd_data());
    repeat (10) step();
    chk("bp_req_held", m_axis_enqueue_req_valid, 1'b1);
    m_axis_enqueue_req_ready = 1; m_axis_dma_ready = 0;
    respond(8'd0, 64'h3000, 1'b1, 8'h22, 1'b0, 1'b0);
    repeat (10) step();
    chk("bp_dma_held", m_axis_dma_valid, 1'b1);
    m_axis_dma_ready = 1; step();
    m_axis_enqueue_commit_ready = 0;
    dma_done = 1; step(); dma_done = 0;
    repeat (10) step();
    chk("bp_commit_held", m_axis_enqueue_commit_valid, 1'b1);
    m_axis_enqueue_commit_ready = 1; step(); step();
    chk("bp_one_commit", obs_commits - c0, 1);
    chk("bp_idle", busy, 1'b0);

    // Reset while waiting for DMA completion
    reset_dut();
    send_cpl(8'd2, rnd_data());
    respond(8'd0, 64'h4000, 1'b1, 8'd3, 1'b0, 1'b0);
    step();
    chk("rw_busy_before", busy, 1'b1);
    c0 = obs_commits;
    rst_n = 0; step(); rst_n = 1;
    dma_done = 1; step(); dma_done = 0;
    repeat (3) step();
    chk("rw_no_commit", obs_commits - c0, 0);
    chk("rw_busy", busy, 1'b0);
    chk("rw_drop", drop_count, 32'd0);
    chk("rw_mis", mismatch_count, 32'd0);

    // Randomized traffic with a reactive queue manager and DMA engine
    reset_dut();
    pend = 0; pend_tag = '0;
    for (int c = 0; c < 4000; c++) begin
      hs_cpl  = s_axis_cpl_valid && s_axis_cpl_ready;
      hs_req  = m_axis_enqueue_req_valid && m_axis_enqueue_req_ready;
      hs_resp = s_axis_enqueue_resp_valid && s_axis_enqueue_resp_ready && (s_axis_enqueue_resp_tag == pend_tag);
      if (!rst_n) pend = 0;
      else begin
        if (hs_req) begin pend = 1; pend_tag = m_axis_enqueue_req_tag; end
        if (hs_resp) pend = 0;
      end
      step();
      rst_n = ($urandom_range(0, 299) != 0);
      if (hs_cpl || !s_axis_cpl_valid) begin
        s_axis_cpl_valid = $urandom_range(0, 1);
        s_axis_cpl_queue = QW'($urandom);
        s_axis_cpl_data = rnd_data();
      end
      m_axis_enqueue_req_ready = ($urandom_range(0, 3) != 0);
      m_axis_dma_ready = ($urandom_range(0, 3) != 0);
      m_axis_enqueue_commit_ready = ($urandom_range(0, 3) != 0);
      dma_done = ($urandom_range(0, 2) == 0);
      s_axis_enqueue_resp_valid = pend ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      s_axis_enqueue_resp_tag = (pend != 0 && $urandom_range(0, 4) != 0) ? pend_tag : TW'($urandom);
      s_axis_enqueue_resp_full = ($urandom_range(0, 5) == 0);
      s_axis_enqueue_resp_error = ($urandom_range(0, 5) == 0);
      s_axis_enqueue_resp_addr = {$urandom, $urandom};
      s_axis_enqueue_resp_op_tag = OW'($urandom);
      s_axis_enqueue_resp_phase = $urandom_range(0, 1);
    end
    rst_n = 1; s_axis_cpl_valid = 0; s_axis_enqueue_resp_valid = 0; dma_done = 0;
    repeat (5) step();

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpl_enqueue_initiator.md
CPL_ENQUEUE_INITIATOR -- requirements
Module: cpl_enqueue_initiator

Interface
REQ-001 SHALL provide parameter QUEUE_INDEX_WIDTH, default 8, completion queue index width.
REQ-002 SHALL provide parameter REQ_TAG_WIDTH, default 8, enqueue request tag width.
REQ-003 SHALL provide parameter OP_TAG_WIDTH, default 8, operation tag width returned by the queue manager.
REQ-004 SHALL provide parameter QUEUE_PTR_WIDTH, default 16, queue pointer width.
REQ-005 SHALL provide parameter ADDR_WIDTH, default 64, DMA address width.
REQ-006 SHALL provide parameter CPL_WIDTH, default 128, completion record width in bits (minimum 2).
REQ-007 SHALL have one clock and a synchronous, active-low reset, with the ports listed first:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
REQ-008 SHALL have the following completion input ports:
- s_axis_cpl_queue  in  QUEUE_INDEX_WIDTH  target completion queue
- s_axis_cpl_data  in  CPL_WIDTH  completion record
- s_axis_cpl_valid / s_axis_cpl_ready  in/out  1  handshake
REQ-009 SHALL have the following enqueue request ports:
- m_axis_enqueue_req_queue  out  QUEUE_INDEX_WIDTH  queue index
- m_axis_enqueue_req_tag  out  REQ_TAG_WIDTH  request tag
- m_axis_enqueue_req_valid / m_axis_enqueue_req_ready  out/in  1  handshake
REQ-010 SHALL have the following enqueue response ports:
- s_axis_enqueue_resp_tag  in  REQ_TAG_WIDTH  echoed tag
- s_axis_enqueue_resp_op_tag  in  OP_TAG_WIDTH  operation tag
- s_axis_enqueue_resp_addr  in  ADDR_WIDTH  slot address
- s_axis_enqueue_resp_phase  in  1  phase bit
- s_axis_enqueue_resp_full, s_axis_enqueue_resp_error  in  1  status
- s_axis_enqueue_resp_valid / s_axis_enqueue_resp_ready  in/out  1  handshake
REQ-011 SHALL have the following DMA write and commit ports:
- m_axis_dma_addr  out  ADDR_WIDTH
- m_axis_dma_data  out  CPL_WIDTH
- m_axis_dma_valid / m_axis_dma_ready  out/in  1  handshake
- dma_done  in  1  one-cycle write-complete pulse
- m_axis_enqueue_commit_op_tag  out  OP_TAG_WIDTH
- m_axis_enqueue_commit_valid / m_axis_enqueue_commit_ready  out/in  1  handshake
REQ-012 SHALL have the following status outputs:
- drop_count  out  32  completions dropped on full/error
- mismatch_count  out  32  responses discarded on tag mismatch
- busy  out  1  FSM not in IDLE

Function
REQ-013 SHALL process one completion at a time using FSM states IDLE, REQ, RESP, WRITE, WAIT_DONE and COMMIT.
REQ-014 SHALL drive s_axis_cpl_ready high only in IDLE; a cpl handshake SHALL latch queue and data and move the FSM to REQ on the next cycle.
REQ-015 In REQ, SHALL assert m_axis_enqueue_req_valid with the latched queue and the current tag, hold all outputs stable until ready, and on handshake move to RESP.
REQ-016 SHALL hold the tag counter at REQ_TAG_WIDTH bits, increment it by 1 on each request handshake, and wrap from all-ones to 0.
REQ-017 SHALL drive s_axis_enqueue_resp_ready high only in RESP.
REQ-018 SHALL accept and discard a response whose tag differs from the outstanding tag, increment mismatch_count, and remain in RESP.
REQ-019 On a matching response with full=1 or error=1, SHALL increment drop_count, perform no DMA write and no commit, and return to IDLE.
REQ-020 On a matching response with full=0 and error=0, SHALL latch addr and op_tag and move to WRITE.
REQ-021 In WRITE, SHALL drive m_axis_dma_data as {phase, latched_data[CPL_WIDTH-2:0]} and m_axis_dma_addr as the latched addr, holding both stable until the handshake, then move to WAIT_DONE.
REQ-022 SHALL ignore dma_done in every state except WAIT_DONE; in WAIT_DONE, dma_done=1 SHALL move the FSM to COMMIT.
REQ-023 In COMMIT, SHALL assert m_axis_enqueue_commit_valid with the latched op_tag and, on handshake, return to IDLE.
REQ-024 SHALL allow a new completion handshake in the cycle after returning to IDLE; best-case latency from cpl handshake to commit valid is 5 cycles with all readies high and dma_done arriving one cycle after the DMA handshake.
REQ-025 SHALL saturate both counters at 0xFFFFFFFF.
REQ-026 SHALL drive busy low exactly when the FSM is in IDLE.

Reset
REQ-027 rst_n=0 sampled on a clk edge SHALL force IDLE, zero the tag counter, drop_count and mismatch_count, and deassert every valid output and every ready output except s_axis_cpl_ready, which goes high.
REQ-028 A reset asserted mid-operation SHALL abandon the in-flight completion without issuing a commit; a later dma_done or response SHALL be ignored while the FSM is in IDLE.

Verification
REQ-029 Bench SHALL cover the nominal path: cpl queue=3 -> req queue=3 tag=0; response tag=0 addr=0x1000 phase=1 op_tag=5 -> DMA addr 0x1000 with data MSB=1; dma_done -> commit op_tag=5; busy returns to 0.
REQ-030 Bench SHALL cover the full response: response full=1 -> drop_count=1, no DMA valid, no commit, back in IDLE.
REQ-031 Bench SHALL cover tag mismatch: response tag=7 while tag 0 is outstanding -> mismatch_count=1 and still in RESP; then response tag=0 -> normal completion.
REQ-032 Bench SHALL cover tag wrap: 256 completions with REQ_TAG_WIDTH=8 -> request 257 carries tag 0.
REQ-033 Bench SHALL cover backpressure: req_ready, dma_ready and commit_ready held low for 10 cycles each -> all payloads stable while valid is high, and exactly one commit issued.
REQ-034 Bench SHALL cover reset in WAIT_DONE: rst_n=0 for 1 cycle, then dma_done pulse -> no commit, busy=0, counters 0.
